// File: rtl/ctrl_pipeline_pkg.sv
// Shared control-word definitions for the E/M/W control pipeline.
// Holds the decoded control struct, the bubble constant and the ResultSrc encodings.
package ctrl_pipeline_pkg;

    localparam int CP_ALU_CTRL_W = 3;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic                     reg_write;
        logic [1:0]               result_src;
        logic                     mem_write;
        logic                     jump;
        logic                     branch;
        logic                     alu_src;
        logic [CP_ALU_CTRL_W-1:0] alu_control;
    } ctrl_word_t;

    localparam int         CTRL_W      = $bits(ctrl_word_t);
    localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: synchronous active-low reset, flush loads a bubble,
// hold keeps the current contents. Reset beats flush, flush beats hold.
module ctrl_stage_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         hold,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg <= '0;
        end else if (flush) begin
            q_reg <= '0;
        end else if (!hold) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoded control words and rd from D through E, M and W with stall/flush.
// Optional performance counters are enabled with the CTRL_PIPE_PERF_CNT_EN macro.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int ALU_CTRL_W = CP_ALU_CTRL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWriteD,
    input  logic [1:0]            ResultSrcD,
    input  logic                  MemWriteD,
    input  logic                  JumpD,
    input  logic                  BranchD,
    input  logic                  ALUSrcD,
    input  logic [ALU_CTRL_W-1:0] ALUControlD,
    input  logic [REG_ADDR_W-1:0] RdD,
    input  logic                  ValidD,
    input  logic                  StallE,
    input  logic                  FlushE,
    input  logic                  ZeroE,
    output logic                  ALUSrcE,
    output logic [ALU_CTRL_W-1:0] ALUControlE,
    output logic                  ResultSrcE0,
    output logic [REG_ADDR_W-1:0] RdE,
    output logic                  PCSrcE,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [REG_ADDR_W-1:0] RdW,
    output logic                  ValidW
`ifdef CTRL_PIPE_PERF_CNT_EN
    ,
    output logic [31:0]           RetireCnt,
    output logic [31:0]           BubbleCnt
`endif
);

    // Stage payloads: E keeps the full word, M and W only what they still consume.
    localparam int E_W = 1 + REG_ADDR_W + CTRL_W;
    localparam int M_W = 1 + REG_ADDR_W + 4;
    localparam int W_W = 1 + REG_ADDR_W + 3;

    ctrl_word_t            ctrl_d;
    ctrl_word_t            ctrl_e;
    logic [E_W-1:0]        e_next;
    logic [E_W-1:0]        e_reg;
    logic [M_W-1:0]        m_next;
    logic [M_W-1:0]        m_reg;
    logic [W_W-1:0]        w_next;
    logic [W_W-1:0]        w_reg;
    logic                  valid_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic                  m_bubble;

    always_comb begin
        ctrl_d             = CTRL_BUBBLE;
        ctrl_d.reg_write   = RegWriteD;
        ctrl_d.result_src  = ResultSrcD;
        ctrl_d.mem_write   = MemWriteD;
        ctrl_d.jump        = JumpD;
        ctrl_d.branch      = BranchD;
        ctrl_d.alu_src     = ALUSrcD;
        ctrl_d.alu_control = ALUControlD;
    end

    // A D word without ValidD enters E as a bubble whatever its control bits say.
    assign e_next = ValidD ? {1'b1, RdD, ctrl_d} : '0;

    ctrl_stage_reg #(.W(E_W)) u_stage_e (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (FlushE),
        .hold  (StallE),
        .d     (e_next),
        .q     (e_reg)
    );

    assign valid_e = e_reg[E_W-1];
    assign rd_e    = e_reg[E_W-2 -: REG_ADDR_W];
    assign ctrl_e  = ctrl_word_t'(e_reg[CTRL_W-1:0]);

    // While E is held its instruction must not also advance, so M takes a bubble.
    assign m_bubble = StallE & ~FlushE;
    assign m_next   = {valid_e, rd_e, ctrl_e.reg_write, ctrl_e.result_src, ctrl_e.mem_write};

    ctrl_stage_reg #(.W(M_W)) u_stage_m (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (m_bubble),
        .hold  (1'b0),
        .d     (m_next),
        .q     (m_reg)
    );

    assign w_next = m_reg[M_W-1:1];

    ctrl_stage_reg #(.W(W_W)) u_stage_w (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (1'b0),
        .hold  (1'b0),
        .d     (w_next),
        .q     (w_reg)
    );

    assign ALUSrcE     = ctrl_e.alu_src;
    assign ALUControlE = ctrl_e.alu_control;
    assign ResultSrcE0 = ctrl_e.result_src[0] & valid_e;
    assign RdE         = rd_e;
    assign PCSrcE      = valid_e & ((ctrl_e.branch & ZeroE) | ctrl_e.jump);

    assign ValidW      = w_reg[W_W-1];
    assign RdW         = w_reg[W_W-2 -: REG_ADDR_W];
    assign RegWriteW   = w_reg[2];
    assign ResultSrcW  = w_reg[1:0];

    assign RdM         = m_reg[M_W-2 -: REG_ADDR_W];
    assign RegWriteM   = m_reg[3];
    assign ResultSrcM  = m_reg[2:1];
    assign MemWriteM   = m_reg[0];

`ifdef CTRL_PIPE_PERF_CNT_EN
    logic [31:0] retire_cnt_reg;
    logic [31:0] bubble_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_cnt_reg <= '0;
            bubble_cnt_reg <= '0;
        end else begin
            if (ValidW) begin
                retire_cnt_reg <= retire_cnt_reg + 32'd1;
            end
            if (FlushE) begin
                bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
            end
        end
    end

    assign RetireCnt = retire_cnt_reg;
    assign BubbleCnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: retiring instructions are scoreboarded at W,
// stage taps are checked at fixed points of each scenario.
module tb_ctrl_pipeline;
    import ctrl_pipeline_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD;
    logic [1:0] ResultSrcD;
    logic [2:0] ALUControlD;
    logic [4:0] RdD;
    logic       StallE, FlushE, ZeroE;
    logic       ALUSrcE, ResultSrcE0, PCSrcE;
    logic [2:0] ALUControlE;
    logic [4:0] RdE, RdM, RdW;
    logic       RegWriteM, MemWriteM, RegWriteW, ValidW;
    logic [1:0] ResultSrcM, ResultSrcW;
`ifdef CTRL_PIPE_PERF_CNT_EN
    logic [31:0] RetireCnt, BubbleCnt;
    logic [31:0] bubble_base;
`endif

    typedef struct packed {
        logic [4:0] rd;
        logic [1:0] rs;
        logic       rw;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   fails   = 0;
    int   retired = 0;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .rst_n(rst_n),
        .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
        .JumpD(JumpD), .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RdD(RdD), .ValidD(ValidD), .StallE(StallE), .FlushE(FlushE), .ZeroE(ZeroE),
        .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE), .ResultSrcE0(ResultSrcE0),
        .RdE(RdE), .PCSrcE(PCSrcE), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .RdM(RdM), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .RdW(RdW), .ValidW(ValidW)
`ifdef CTRL_PIPE_PERF_CNT_EN
        , .RetireCnt(RetireCnt), .BubbleCnt(BubbleCnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic [1:0] rs, input logic mw,
                         input logic j, input logic b, input logic as, input logic [2:0] ac,
                         input logic [4:0] rd);
        ValidD = v; RegWriteD = rw; ResultSrcD = rs; MemWriteD = mw;
        JumpD = j; BranchD = b; ALUSrcD = as; ALUControlD = ac; RdD = rd;
    endtask

    // One clock: scoreboard push on capture into E, pop and compare on retire at W.
    task automatic tick();
        logic cap;
        exp_t e;
        exp_t got;
        cap = rst_n & ValidD & ~FlushE & ~StallE;
        e   = '{rd: RdD, rs: ResultSrcD, rw: RegWriteD};
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            retired = 0;
        end else if (cap) begin
            sb.push_back(e);
        end
        #1;
        if (ValidW === 1'b1) begin
            retired++;
            got = '{rd: RdW, rs: ResultSrcW, rw: RegWriteW};
            if (sb.size() == 0) begin
                chk("retire_unexpected", {59'd0, got}, 64'd0);
            end else begin
                chk("retire_word", {59'd0, got}, {59'd0, sb.pop_front()});
            end
        end
        $display("cycle rst_n=%0b D(v=%0b rd=%0d) stall=%0b flush=%0b | RdE=%0d PCSrcE=%0b RdM=%0d RegWriteM=%0b | W(v=%0b rd=%0d rs=%0d)",
                 rst_n, ValidD, RdD, StallE, FlushE, RdE, PCSrcE, RdM, RegWriteM, ValidW, RdW, ResultSrcW);
    endtask

    function automatic logic [63:0] all_outs();
        return {35'd0, ALUSrcE, ALUControlE, ResultSrcE0, RdE, PCSrcE, RegWriteM, MemWriteM,
                ResultSrcM, RdM, RegWriteW, ResultSrcW, RdW, ValidW};
    endfunction

    initial begin
        rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0; ZeroE = 1'b0;
        // Reset held with an active lw on D.
        drive(1, 1, RES_MEM, 0, 0, 0, 1, 3'b000, 5'd5);
        tick(); chk("reset_outs_1", all_outs(), 64'd0);
        tick(); chk("reset_outs_2", all_outs(), 64'd0);
`ifdef CTRL_PIPE_PERF_CNT_EN
        chk("reset_retire_cnt", {32'd0, RetireCnt}, 64'd0);
        chk("reset_bubble_cnt", {32'd0, BubbleCnt}, 64'd0);
`endif

        // lw x5: E, M, then W three cycles after presentation.
        rst_n = 1'b1;
        tick();
        chk("lw_RdE", {59'd0, RdE}, 64'd5);
        chk("lw_ResultSrcE0", {63'd0, ResultSrcE0}, 64'd1);
        chk("lw_ALUSrcE", {63'd0, ALUSrcE}, 64'd1);
        drive(0, 1, RES_MEM, 1, 1, 1, 1, 3'b111, 5'd9);
        tick();
        chk("lw_RegWriteM", {63'd0, RegWriteM}, 64'd1);
        chk("lw_RdM", {59'd0, RdM}, 64'd5);
        chk("gate_RdE", {59'd0, RdE}, 64'd0);
        chk("gate_PCSrcE", {63'd0, PCSrcE}, 64'd0);
        chk("lw_not_early_W", {63'd0, ValidW}, 64'd0);
        drive(0, 0, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd0);
        tick();
        chk("lw_ValidW", {63'd0, ValidW}, 64'd1);
        chk("lw_RdW", {59'd0, RdW}, 64'd5);
        chk("lw_ResultSrcW", {62'd0, ResultSrcW}, {62'd0, RES_MEM});
        chk("gate_RegWriteM", {63'd0, RegWriteM}, 64'd0);

        // beq taken then not taken.
        drive(1, 0, RES_ALU, 0, 0, 1, 0, 3'b001, 5'd0);
        tick(); ZeroE = 1'b1; #1;
        chk("beq_taken", {63'd0, PCSrcE}, 64'd1);
        chk("beq_ALUControlE", {61'd0, ALUControlE}, 64'd1);
        drive(0, 0, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd0);
        tick();
        chk("beq_one_cycle", {63'd0, PCSrcE}, 64'd0);
        drive(1, 0, RES_ALU, 0, 0, 1, 0, 3'b001, 5'd0);
        tick(); ZeroE = 1'b0; #1;
        chk("beq_not_taken", {63'd0, PCSrcE}, 64'd0);

        // jal x1, then flush the following add x7.
        drive(1, 1, RES_PC4, 0, 1, 0, 0, 3'b000, 5'd1);
        tick();
        chk("jal_PCSrcE", {63'd0, PCSrcE}, 64'd1);
        drive(1, 1, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd7);
        FlushE = 1'b1;
        tick();
        FlushE = 1'b0;
        chk("flush_RdE", {59'd0, RdE}, 64'd0);
        chk("flush_PCSrcE", {63'd0, PCSrcE}, 64'd0);
        chk("jal_RdM", {59'd0, RdM}, 64'd1);
        drive(0, 0, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd0);
        tick();
        chk("flush_RegWriteM", {63'd0, RegWriteM}, 64'd0);
        chk("jal_ResultSrcW", {62'd0, ResultSrcW}, {62'd0, RES_PC4});
        chk("jal_RdW", {59'd0, RdW}, 64'd1);

        // Load-use stall with add x3 in E.
        drive(1, 1, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd3);
        tick();
        chk("add3_RdE", {59'd0, RdE}, 64'd3);
        drive(1, 1, RES_ALU, 0, 0, 0, 0, 3'b010, 5'd4);
        StallE = 1'b1;
        tick();
        StallE = 1'b0;
        chk("stall_RdE_held", {59'd0, RdE}, 64'd3);
        chk("stall_RegWriteM", {63'd0, RegWriteM}, 64'd0);
        tick();
        chk("after_stall_RdE", {59'd0, RdE}, 64'd4);
        chk("after_stall_RdM", {59'd0, RdM}, 64'd3);
        chk("stall_W_bubble", {63'd0, ValidW}, 64'd0);
        drive(0, 0, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd0);
        tick();
        chk("stall_x3_RdW", {59'd0, RdW}, 64'd3);
        chk("stall_x3_ValidW", {63'd0, ValidW}, 64'd1);

        // Stall and flush together with jal x2 in E.
        drive(1, 1, RES_PC4, 0, 1, 0, 0, 3'b000, 5'd2);
        tick();
        chk("jal2_PCSrcE", {63'd0, PCSrcE}, 64'd1);
`ifdef CTRL_PIPE_PERF_CNT_EN
        bubble_base = BubbleCnt;
`endif
        drive(1, 1, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd6);
        StallE = 1'b1; FlushE = 1'b1;
        tick();
        StallE = 1'b0; FlushE = 1'b0;
        chk("sf_RdE", {59'd0, RdE}, 64'd0);
        chk("sf_PCSrcE", {63'd0, PCSrcE}, 64'd0);
        chk("sf_RdM", {59'd0, RdM}, 64'd2);
`ifdef CTRL_PIPE_PERF_CNT_EN
        chk("sf_BubbleCnt", {32'd0, BubbleCnt}, {32'd0, bubble_base + 32'd1});
`endif
        drive(0, 0, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd0);
        tick(); tick(); tick();

        // sw in M when reset hits.
        drive(1, 0, RES_ALU, 1, 0, 0, 1, 3'b000, 5'd0);
        tick();
        drive(0, 0, RES_ALU, 0, 0, 0, 0, 3'b000, 5'd0);
        tick();
        chk("sw_MemWriteM", {63'd0, MemWriteM}, 64'd1);
`ifdef CTRL_PIPE_PERF_CNT_EN
        chk("pre_reset_RetireCnt", {32'd0, RetireCnt}, 64'(retired));
`endif
        rst_n = 1'b0;
        tick();
        chk("midrst_MemWriteM", {63'd0, MemWriteM}, 64'd0);
        chk("midrst_outs", all_outs(), 64'd0);
`ifdef CTRL_PIPE_PERF_CNT_EN
        chk("midrst_RetireCnt", {32'd0, RetireCnt}, 64'd0);
`endif
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("no_partial_retire", {63'd0, ValidW}, 64'd0);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
- Consumer end of the main-decoder control bus.
- Registers the decode-stage control word and destination register through the E, M and W pipeline stages, and applies hazard-unit stall/flush.
- Produces the per-stage control taps needed by the datapath, the forwarding unit and the hazard unit, including the branch/jump redirect PCSrcE.
- Sits between the decoder/ALU-decoder (D stage) and the datapath stage registers.

Parameters:
- REG_ADDR_W, 5, width of rd field.
- ALU_CTRL_W, 3, width of ALUControl from ALU decoder.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- RegWriteD  in  1  D-stage control
- ResultSrcD  in  2  D-stage control
- MemWriteD  in  1  D-stage control
- JumpD  in  1  D-stage control
- BranchD  in  1  D-stage control
- ALUSrcD  in  1  D-stage control
- ALUControlD  in  ALU_CTRL_W  D-stage control
- RdD  in  REG_ADDR_W  destination register
- ValidD  in  1  D holds a real instruction
- StallE  in  1  hold E stage
- FlushE  in  1  replace E with bubble
- ZeroE  in  1  ALU zero flag, E stage
- ALUSrcE, ALUControlE  out  1 / ALU_CTRL_W  E-stage datapath controls
- ResultSrcE0  out  1  E-stage load indicator for hazard unit
- RdE  out  REG_ADDR_W  for hazard unit
- PCSrcE  out  1  redirect fetch
- RegWriteM, MemWriteM  out  1  M-stage controls
- ResultSrcM  out  2  M-stage control
- RdM  out  REG_ADDR_W  forwarding tap
- RegWriteW  out  1  W-stage control
- ResultSrcW  out  2  W-stage control
- RdW  out  REG_ADDR_W  forwarding tap
- ValidW  out  1  instruction retiring this cycle

Behaviour:
- Reset: clk edge with rst_n=0 clears every stage register to 0, so all outputs are 0 the following cycle and PCSrcE=0. Reset mid-stream discards all in-flight instructions, with no partial retire.
- Bubble: all control bits 0, Rd 0, valid 0. A bubble never writes the register file or memory and never redirects.
- Gating: a D word with ValidD=0 enters E as a bubble regardless of the other D inputs.
- Latency: D→E, E→M and M→W each take one cycle. An instruction presented in cycle N appears in E at N+1, M at N+2 and W at N+3.
- E-stage update priority per edge: rst_n=0 first, then FlushE (load bubble), then StallE (hold current E), else load from D. FlushE together with StallE gives a bubble.
- M-stage update: when StallE=1 and FlushE=0, M loads a bubble (E is held and must not be duplicated). Otherwise M loads from E.
- W-stage update: W always loads from M; no stall.
- PCSrcE = ValidE & ((BranchE & ZeroE) | JumpE). It is combinational from the E registers and ZeroE. A bubble in E forces 0.
- ResultSrcE0 = ResultSrcE[0] & ValidE.
- All other outputs are direct register outputs with no combinational path from D inputs.
- Widths are fixed by parameters; there is no arithmetic except in the optional counters.

Optional Feature:
- Macro CTRL_PIPE_PERF_CNT_EN.
- When defined: adds outputs RetireCnt [31:0] and BubbleCnt [31:0].
  - RetireCnt increments each cycle ValidW=1.
  - BubbleCnt increments each edge on which E loads a bubble due to FlushE.
  - Both wrap modulo 2^32, clear on reset, and increment at most once per cycle.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - a ctrl_word struct/typedef {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUSrc, ALUControl}
  - constant CTRL_BUBBLE = all zeros
  - ResultSrc encodings: RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10
- One natural sub-module, ctrl_stage_reg: a parameterised-width register with rst_n, flush (load bubble) and hold, instantiated three times.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with the D inputs active → all outputs 0; release, then present a lw (RegWriteD=1, ResultSrcD=01, ALUSrcD=1, RdD=5) → RdW=5, ResultSrcW=01, ValidW=1 exactly 3 cycles later.
- Branch taken: beq (BranchD=1, ALUControlD=001) with ZeroE=1 in its E cycle → PCSrcE=1 for that cycle only. Same with ZeroE=0 → PCSrcE=0.
- Jump with flush: jal in E (JumpD=1, RdD=1, ResultSrcD=10) → PCSrcE=1. FlushE=1 on the next edge → the following instruction becomes a bubble, RegWriteM=0 one cycle later, and the jal reaches W with ResultSrcW=10, RdW=1.
- Load-use stall: StallE=1 for one cycle with add x3 in E → RdE stays 3, M gets a bubble (RegWriteM=0), and x3 reaches W one cycle later than unstalled.
- Simultaneous: StallE=1 and FlushE=1 → E becomes a bubble (ValidE=0, PCSrcE=0); with CTRL_PIPE_PERF_CNT_EN, BubbleCnt increments by 1.
- Mid-operation reset: rst_n=0 while sw (MemWriteD=1) is in M → MemWriteM=0 after the edge, and RetireCnt=0.
